// File: rtl/pacman_plotter_if.sv
// ---------------------------------------------------------------------------
// pacman_plotter_if
//   Bundles the sprite request coming from the Pac-Man controller and the
//   pixel-plot stream going to the VGA frame buffer adapter.
//   Request side : go (frame tick), shape (5x5 bitmap), tile_x, tile_y
//   Plot side    : vga_x, vga_y, colour, plot (write strobe), busy, done
//   modport slave  - used by the plotter (consumes requests, emits plots)
//   modport master - used by whoever drives requests and watches the plots
// ---------------------------------------------------------------------------
interface pacman_plotter_if;
  logic        go;
  logic [24:0] shape;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport slave (
    input  go, shape, tile_x, tile_y,
    output vga_x, vga_y, colour, plot, busy, done
  );

  modport master (
    output go, shape, tile_x, tile_y,
    input  vga_x, vga_y, colour, plot, busy, done
  );
endinterface

// File: rtl/pacman_plotter.sv
// ---------------------------------------------------------------------------
// pacman_plotter
//   Plots the 5x5 Pac-Man sprite into the VGA frame buffer one pixel per clock.
//   On each frame tick (go) it erases the sprite at its previous tile (only if
//   the tile moved), draws it at the new tile, then pulses done.
//   Ports:
//     clock   - system clock, rising edge
//     reset_n - asynchronous active-low reset
//     bus     - pacman_plotter_if.slave (go/shape/tile_x/tile_y in,
//               vga_x/vga_y/colour/plot/busy/done out, all outputs registered)
// ---------------------------------------------------------------------------
module pacman_plotter #(
  parameter int          TILE_PX    = 5,
  parameter int          X_OFF      = 10,
  parameter int          Y_OFF      = 0,
  parameter logic [2:0]  PAC_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
  input  logic              clock,
  input  logic              reset_n,
  pacman_plotter_if.slave   bus
);

  // The base pixel is nominally computed at 16 bits and then truncated.
  // The low bits of a product/sum depend only on the low bits of the operands,
  // so computing directly at the output width yields the same wrapped value.
  localparam logic [7:0] TILE_X = 8'(TILE_PX);
  localparam logic [7:0] X_BASE = 8'(X_OFF);
  localparam logic [6:0] TILE_Y = 7'(TILE_PX);
  localparam logic [6:0] Y_BASE = 7'(Y_OFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] base_x(input logic [7:0] tx);
    return tx * TILE_X + X_BASE;
  endfunction

  function automatic logic [6:0] base_y(input logic [6:0] ty);
    return ty * TILE_Y + Y_BASE;
  endfunction

  // Bitmap index of pixel (row, col): row-major, col fastest.
  function automatic logic [4:0] pix_idx(input logic [2:0] row, input logic [2:0] col);
    return {2'b00, row} * 5'd5 + {2'b00, col};
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [24:0] cur_shape_q, cur_shape_d;
  logic [7:0]  cur_x_q, cur_x_d;
  logic [6:0]  cur_y_q, cur_y_d;
  logic [7:0]  prev_x_q, prev_x_d;
  logic [6:0]  prev_y_q, prev_y_d;
  logic        prev_valid_q, prev_valid_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        last_pix_s;
  logic [7:0]  cur_bx_s;
  logic [6:0]  cur_by_s;
  logic [7:0]  prev_bx_s;
  logic [6:0]  prev_by_s;

  assign last_pix_s = (row_q == 3'd4) && (col_q == 3'd4);
  assign cur_bx_s   = base_x(cur_x_q);
  assign cur_by_s   = base_y(cur_y_q);
  assign prev_bx_s  = base_x(prev_x_q);
  assign prev_by_s  = base_y(prev_y_q);

  // Next-state, pixel scan and registered-output computation.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cur_shape_d  = cur_shape_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Outputs lag the state by one cycle, so busy_q is still high during
        // the visible done cycle; a go seen then is dropped, not queued.
        if (bus.go && !busy_q) begin
          cur_shape_d = bus.shape;
          cur_x_d     = bus.tile_x;
          cur_y_d     = bus.tile_y;
          col_d       = 3'd0;
          row_d       = 3'd0;
          if (prev_valid_q && ((prev_x_q != bus.tile_x) || (prev_y_q != bus.tile_y))) begin
            state_d = ST_ERASE;
          end else begin
            state_d = ST_DRAW;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ERASE: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        vga_x_d  = prev_bx_s + {5'b00000, col_q};
        vga_y_d  = prev_by_s + {4'b0000, row_q};
        colour_d = BG_COLOUR;
        if (last_pix_s) begin
          state_d = ST_DRAW;
          col_d   = 3'd0;
          row_d   = 3'd0;
        end else if (col_q == 3'd4) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end

      ST_DRAW: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        vga_x_d  = cur_bx_s + {5'b00000, col_q};
        vga_y_d  = cur_by_s + {4'b0000, row_q};
        colour_d = cur_shape_q[pix_idx(row_q, col_q)] ? PAC_COLOUR : BG_COLOUR;
        if (last_pix_s) begin
          state_d = ST_DONE;
          col_d   = 3'd0;
          row_d   = 3'd0;
        end else if (col_q == 3'd4) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end

      ST_DONE: begin
        busy_d       = 1'b1;
        done_d       = 1'b1;
        prev_x_d     = cur_x_q;
        prev_y_d     = cur_y_q;
        prev_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, scan counters, latched sprite and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      col_q        <= 3'd0;
      row_q        <= 3'd0;
      cur_shape_q  <= 25'd0;
      cur_x_q      <= 8'd0;
      cur_y_q      <= 7'd0;
      prev_x_q     <= 8'd0;
      prev_y_q     <= 7'd0;
      prev_valid_q <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cur_shape_q  <= cur_shape_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_pacman_plotter.sv
// ---------------------------------------------------------------------------
// tb_pacman_plotter
//   Scoreboard bench: each issued pass pushes its expected pixel stream and
//   done marker; a negedge monitor pops and compares whatever the plotter
//   emits. The issuing task also checks pass timing (plot count, busy length,
//   done latency).
// ---------------------------------------------------------------------------
module tb_pacman_plotter;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  pacman_plotter_if bus ();

  pacman_plotter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model of the plotter's memory of the last drawn tile.
  bit   m_prev_valid = 1'b0;
  int   m_ptx = 0;
  int   m_pty = 0;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every plot or done pulse consumes one scoreboard entry.
  exp_t e;
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus.plot === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("plot_not_done", int'(e.is_done), 0);
          check("vga_x", int'(bus.vga_x), int'(e.x));
          check("vga_y", int'(bus.vga_y), int'(e.y));
          check("colour", int'(bus.colour), int'(e.colour));
        end
      end
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_marker", int'(e.is_done), 1);
        end
      end
    end
  end

  // Expected pixel stream of one pass, from the sprite rules in plain arithmetic.
  task automatic model_pass(input logic [24:0] sh, input int tx, input int ty, output bit erased);
    erased = m_prev_valid && ((m_ptx != tx) || (m_pty != ty));
    if (erased) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          exp_q.push_back('{1'b0, 8'((m_ptx * 5 + 10 + c) % 256),
                            7'((m_pty * 5 + r) % 128), 3'b000});
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_q.push_back('{1'b0, 8'((tx * 5 + 10 + c) % 256),
                          7'((ty * 5 + r) % 128),
                          (sh[r * 5 + c] ? 3'b110 : 3'b000)});
    exp_q.push_back('{1'b1, 8'd0, 7'd0, 3'd0});
    m_prev_valid = 1'b1;
    m_ptx = tx;
    m_pty = ty;
  endtask

  // One pass. Cycle 1 is the cycle after the edge that samples go.
  // inject_cycle: pulse go with a new shape in that cycle (0 = never).
  // reset_cycle : assert reset_n in that cycle and abandon the pass (0 = never).
  task automatic run_pass(input logic [24:0] sh, input int tx, input int ty,
                          input int inject_cycle, input int reset_cycle);
    bit erased;
    int done_cycle = 0;
    int busy_cnt   = 0;
    int plot_cnt   = 0;
    int cyc;
    @(posedge clock); #1;
    bus.go     = 1'b1;
    bus.shape  = sh;
    bus.tile_x = 8'(tx);
    bus.tile_y = 7'(ty);
    model_pass(sh, tx, ty, erased);
    @(posedge clock); #1;
    bus.go     = 1'b0;
    bus.shape  = 25'($urandom);
    bus.tile_x = 8'($urandom);
    bus.tile_y = 7'($urandom);
    cyc = 1;
    check("cycle1_quiet", int'(bus.plot | bus.busy | bus.done), 0);
    while (done_cycle == 0 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == inject_cycle) begin
        bus.go    = 1'b1;
        bus.shape = 25'($urandom);
      end else begin
        bus.go = 1'b0;
      end
      if (cyc == reset_cycle) begin
        reset_n = 1'b0;
        #1;
        check("reset_plot", int'(bus.plot), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        exp_q.delete();
        m_prev_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset_quiet", int'(bus.plot | bus.busy | bus.done), 0);
        return;
      end
      if (bus.busy) busy_cnt++;
      if (bus.plot) plot_cnt++;
      if (bus.done) done_cycle = cyc;
    end
    bus.go = 1'b0;
    check("done_cycle", done_cycle, erased ? 52 : 27);
    check("busy_cycles", busy_cnt, erased ? 51 : 26);
    check("plot_count", plot_cnt, erased ? 50 : 25);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("idle_after_done", int'(bus.plot | bus.busy | bus.done), 0);
    end
  endtask

  initial begin
    int tx;
    int ty;
    reset_n    = 1'b0;
    bus.go     = 1'b0;
    bus.shape  = 25'd0;
    bus.tile_x = 8'd0;
    bus.tile_y = 7'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_xyc", int'({bus.vga_x, bus.vga_y, bus.colour}), 0);
    reset_n = 1'b1;

    run_pass(25'h1FFFFFF, 13, 18, 0, 0);   // first pass: no erase, full yellow
    run_pass(25'h1FFFFFF, 14, 18, 0, 0);   // moved: erase then draw
    run_pass(25'h0000001, 14, 18, 0, 0);   // same tile: erase skipped, one lit pixel
    run_pass(25'h0A5A5A5, 14, 18, 12, 0);  // go + shape change at draw pixel 10
    run_pass(25'h1234567, 20, 5, 0, 40);   // reset in the middle of draw
    run_pass(25'h0F0F0F0, 20, 5, 0, 0);    // prev cleared: no erase
    run_pass(25'h1555555, 40, 30, 0, 0);   // wrapped coordinates

    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        tx = m_ptx;
        ty = m_pty;
      end else begin
        tx = int'($urandom_range(0, 60));
        ty = int'($urandom_range(0, 30));
      end
      run_pass(25'($urandom), tx, ty, (n % 3 == 0) ? int'($urandom_range(2, 20)) : 0, 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
